fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter sharing the single write port of the team's async FIFO among NUM_REQ requesters.
- Sits entirely in the write-clock domain, directly in front of the FIFO's wr_en/wr_data/wr_full interface.
- Grants one requester at a time for a burst of up to MAX_BURST beats.
- Honours wr_full back-pressure, so no write is ever issued into a full FIFO.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/rr_pick.sv | 41 ++++
 rtl/fifo_wr_arbiter.sv | 171 +++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Definitions shared by the async FIFO and the logic around it.
//   arb_state_e      : write-arbiter state encoding (ST_IDLE=0, ST_GRANT=1)
//   FIFO_DATA_WIDTH  : default FIFO data width
//   FIFO_DEPTH       : default FIFO depth
// ----------------------------------------------------------------------------
package fifo_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH      = 16;

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin first-set-bit finder. It scans req_i starting at
// last_ptr_i+1 and wrapping modulo NUM_REQ. It is also used by the read-side
// scheduler.
// Ports:
//   req_i      in  NUM_REQ  request vector
//   last_ptr_i in  ID_BITS  index granted last; it has the lowest priority
//   found_o    out 1        at least one request is set
//   idx_o      out ID_BITS  index of the winning request (0 when none)
// ----------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_BITS = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_BITS-1:0] last_ptr_i,
  output logic               found_o,
  output logic [ID_BITS-1:0] idx_o
);

  // Two descending passes. The lowest index wins inside each pass. The second
  // pass covers indices above last_ptr, so it overrides the wrapped pass.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_i[j] && (ID_BITS'(j) <= last_ptr_i)) begin
        found_o = 1'b1;
        idx_o   = ID_BITS'(j);
      end
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_i[j] && (ID_BITS'(j) > last_ptr_i)) begin
        found_o = 1'b1;
        idx_o   = ID_BITS'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter in front of the async FIFO write port (write clock
// domain). It grants one requester for a burst of up to MAX_BURST beats and
// never writes into a full FIFO.
//
// Ports:
//   wr_clk     in   1                   write-domain clock
//   wr_rst     in   1                   synchronous active-high reset
//   req_valid  in   NUM_REQ             per-requester valid
//   req_data   in   NUM_REQ*DATA_WIDTH  packed requester data
//   req_ready  out  NUM_REQ             per-requester accept
//   wr_en      out  1                   FIFO write enable
//   wr_data    out  DATA_WIDTH          FIFO write data
//   wr_full    in   1                   FIFO full
//   grant_id   out  ID_BITS             current / last granted requester
//   busy       out  1                   high in GRANT
//   stall_cnt  out  16                  only with FIFO_ARB_STALL_CNT_EN:
//                                       saturating count of full-stall cycles
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no grant; pick the next valid requester after last_ptr
// ST_GRANT | grant_id owns the FIFO port until burst end or valid drop
// ----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int MAX_BURST  = 4,
  parameter int ID_BITS    = $clog2(NUM_REQ)
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          wr_full,
  output logic [ID_BITS-1:0]            grant_id,
  output logic                          busy
`ifdef FIFO_ARB_STALL_CNT_EN
  ,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int                    BEAT_BITS = $clog2(MAX_BURST) + 1;
  localparam logic [BEAT_BITS-1:0]  LAST_BEAT = BEAT_BITS'(MAX_BURST - 1);
  localparam logic [ID_BITS-1:0]    LAST_IDX  = ID_BITS'(NUM_REQ - 1);

  arb_state_e           state_q, state_d;
  logic [ID_BITS-1:0]   grant_id_q, grant_id_d;
  logic [ID_BITS-1:0]   last_ptr_q, last_ptr_d;
  logic [BEAT_BITS-1:0] beat_cnt_q, beat_cnt_d;

  logic                  pick_found;
  logic [ID_BITS-1:0]    pick_idx;
  logic                  g_valid;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  xfer;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_BITS (ID_BITS)
  ) u_rr_pick (
    .req_i      (req_valid),
    .last_ptr_i (last_ptr_q),
    .found_o    (pick_found),
    .idx_o      (pick_idx)
  );

  // Select the valid bit and data of the granted requester.
  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_BITS'(i) == grant_id_q) begin
        g_valid = req_valid[i];
        g_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_ptr_d = last_ptr_q;
    beat_cnt_d = beat_cnt_q;
    req_ready  = '0;
    wr_en      = 1'b0;
    wr_data    = '0;
    busy       = 1'b0;
    xfer       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_id_d = pick_idx;
          last_ptr_d = pick_idx;
          beat_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end

      ST_GRANT: begin
        busy    = 1'b1;
        wr_data = g_data;
        xfer    = g_valid && !wr_full;
        wr_en   = xfer;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (ID_BITS'(i) == grant_id_q) begin
            req_ready[i] = !wr_full;
          end
        end
        if (!g_valid) begin
          state_d = ST_IDLE;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Reset aborts a burst in the same cycle, not only after the edge.
    if (wr_rst) begin
      req_ready = '0;
      wr_en     = 1'b0;
      wr_data   = '0;
      busy      = 1'b0;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state_q    <= ST_IDLE;
      grant_id_q <= '0;
      last_ptr_q <= LAST_IDX;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_ptr_q <= last_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant_id = grant_id_q;

`ifdef FIFO_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      stall_cnt_q <= '0;
    end else if ((state_q == ST_GRANT) && g_valid && wr_full &&
                 (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Cycle table for reset, short burst, back-pressure, skip and mid-burst
// reset, followed by a continuous all-valid round-robin run. The expected
// write data goes through a queue that is checked on every wr_en.
// ----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  logic        wr_clk;
  logic        wr_rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        wr_full;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef FIFO_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  fifo_wr_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .MAX_BURST  (4)
  ) dut (
    .wr_clk    (wr_clk),
    .wr_rst    (wr_rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_full   (wr_full),
    .grant_id  (grant_id),
    .busy      (busy)
`ifdef FIFO_ARB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        full;
    logic        exp_en;
    logic [7:0]  exp_wd;
    logic [3:0]  exp_ready;
    logic        exp_busy;
    logic [1:0]  exp_gid;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } sb_t;

  vec_t vt[$];
  sb_t  sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [3:0] valid, input logic [31:0] data,
                     input logic full, input logic en, input logic [7:0] wd,
                     input logic [3:0] rdy, input logic bsy, input logic [1:0] gid);
    vec_t v;
    v.rst = rst; v.valid = valid; v.data = data; v.full = full;
    v.exp_en = en; v.exp_wd = wd; v.exp_ready = rdy; v.exp_busy = bsy; v.exp_gid = gid;
    vt.push_back(v);
  endtask

  // Called at the negedge. It pops one expected beat per observed write.
  // cyc < 0 means that beat carries no timing expectation.
  task automatic sb_check(input int cyc);
    sb_t e;
    if (wr_en === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_write", {24'h0, wr_data}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("write_data", {24'h0, wr_data}, {24'h0, e.data});
        if (e.cyc >= 0) chk("write_cycle", cyc, e.cyc);
      end
    end
  endtask

  initial begin
    logic [3:0] cnt [4];
    logic [3:0] fire;
    sb_t        e;

    // reset check (cycles 0-1) with every requester valid
    add(1, 4'hF, 32'h0,        0, 0, 8'h00, 4'h0, 0, 2'd0);
    add(1, 4'hF, 32'h0,        0, 0, 8'h00, 4'h0, 0, 2'd0);
    add(0, 4'hF, 32'h0,        0, 0, 8'h00, 4'h0, 0, 2'd0);
    add(0, 4'h1, 32'h000000A1, 0, 1, 8'hA1, 4'h1, 1, 2'd0);
    add(0, 4'h0, 32'h0,        0, 0, 8'h00, 4'h1, 1, 2'd0);
    // short burst from requester 2
    add(0, 4'h4, 32'h00210000, 0, 0, 8'h00, 4'h0, 0, 2'd0);
    add(0, 4'h4, 32'h00210000, 0, 1, 8'h21, 4'h4, 1, 2'd2);
    add(0, 4'h4, 32'h00220000, 0, 1, 8'h22, 4'h4, 1, 2'd2);
    add(0, 4'h0, 32'h0,        0, 0, 8'h00, 4'h4, 1, 2'd2);
    add(0, 4'h0, 32'h0,        0, 0, 8'h00, 4'h0, 0, 2'd2);
    // back-pressure on requester 3 after beat 2 (vectors 13-17 are full)
    add(0, 4'h8, 32'h31000000, 0, 0, 8'h00, 4'h0, 0, 2'd2);
    add(0, 4'h8, 32'h31000000, 0, 1, 8'h31, 4'h8, 1, 2'd3);
    add(0, 4'h8, 32'h32000000, 0, 1, 8'h32, 4'h8, 1, 2'd3);
    for (int k = 0; k < 5; k++)
      add(0, 4'h8, 32'h33000000, 1, 0, 8'h00, 4'h0, 1, 2'd3);
    add(0, 4'h8, 32'h33000000, 0, 1, 8'h33, 4'h8, 1, 2'd3);
    add(0, 4'h8, 32'h34000000, 0, 1, 8'h34, 4'h8, 1, 2'd3);
    add(0, 4'h0, 32'h0,        0, 0, 8'h00, 4'h0, 0, 2'd3);
    // skip: last grant is 1, requesters 1 and 3 valid -> 3, then 1
    add(0, 4'h2, 32'h00004100, 0, 0, 8'h00, 4'h0, 0, 2'd3);
    add(0, 4'h2, 32'h00004100, 0, 1, 8'h41, 4'h2, 1, 2'd1);
    add(0, 4'h0, 32'h0,        0, 0, 8'h00, 4'h2, 1, 2'd1);
    add(0, 4'hA, 32'h52005100, 0, 0, 8'h00, 4'h0, 0, 2'd1);
    add(0, 4'hA, 32'h52005100, 0, 1, 8'h52, 4'h8, 1, 2'd3);
    add(0, 4'h2, 32'h00005100, 0, 0, 8'h00, 4'h8, 1, 2'd3);
    add(0, 4'h2, 32'h00005100, 0, 0, 8'h00, 4'h0, 0, 2'd3);
    add(0, 4'h2, 32'h00005100, 0, 1, 8'h51, 4'h2, 1, 2'd1);
    add(0, 4'h0, 32'h0,        0, 0, 8'h00, 4'h2, 1, 2'd1);
    // mid-burst reset on requester 0 (vector 32), then restart at 0
    add(0, 4'h1, 32'h00000061, 0, 0, 8'h00, 4'h0, 0, 2'd1);
    add(0, 4'h1, 32'h00000061, 0, 1, 8'h61, 4'h1, 1, 2'd0);
    add(1, 4'h1, 32'h00000062, 0, 0, 8'h00, 4'h0, 0, 2'd0);
    add(0, 4'h3, 32'h00007163, 0, 0, 8'h00, 4'h0, 0, 2'd0);
    add(0, 4'h3, 32'h00007163, 0, 1, 8'h63, 4'h1, 1, 2'd0);
    add(0, 4'h2, 32'h00007100, 0, 0, 8'h00, 4'h1, 1, 2'd0);
    add(0, 4'h2, 32'h00007100, 0, 0, 8'h00, 4'h0, 0, 2'd0);
    add(0, 4'h2, 32'h00007100, 0, 1, 8'h71, 4'h2, 1, 2'd1);
    add(0, 4'h0, 32'h0,        0, 0, 8'h00, 4'h2, 1, 2'd1);
    add(0, 4'h0, 32'h0,        0, 0, 8'h00, 4'h0, 0, 2'd1);

    wr_rst    = 1'b1;
    req_valid = '0;
    req_data  = '0;
    wr_full   = 1'b0;
    repeat (2) @(posedge wr_clk);
    #1;

    for (int i = 0; i < vt.size(); i++) begin
      wr_rst    = vt[i].rst;
      req_valid = vt[i].valid;
      req_data  = vt[i].data;
      wr_full   = vt[i].full;
      if (vt[i].exp_en) begin
        e.data = vt[i].exp_wd;
        e.cyc  = -1;
        sb_q.push_back(e);
      end
      @(negedge wr_clk);
      chk($sformatf("v%0d_wr_en", i),     {31'h0, wr_en},     {31'h0, vt[i].exp_en});
      chk($sformatf("v%0d_req_ready", i), {28'h0, req_ready}, {28'h0, vt[i].exp_ready});
      chk($sformatf("v%0d_busy", i),      {31'h0, busy},      {31'h0, vt[i].exp_busy});
      chk($sformatf("v%0d_grant_id", i),  {30'h0, grant_id},  {30'h0, vt[i].exp_gid});
`ifdef FIFO_ARB_STALL_CNT_EN
      if (i == 0 || i == 33) chk($sformatf("v%0d_stall_cnt", i), {16'h0, stall_cnt}, 32'd0);
      if (i == 18)           chk("stall_cnt_bp", {16'h0, stall_cnt}, 32'd5);
`endif
      sb_check(-1);
      @(posedge wr_clk);
      #1;
    end
    chk("table_beats_left", sb_q.size(), 0);
    sb_q.delete();

    // Continuous round-robin: 20 beats, grant order 0,1,2,3,0, with one
    // bubble cycle between bursts.
    wr_rst    = 1'b1;
    req_valid = '0;
    @(posedge wr_clk);
    #1;
    wr_rst = 1'b0;
    for (int i = 0; i < 4; i++) cnt[i] = '0;
    fire = '0;
    for (int k = 0; k < 20; k++) begin
      e.data = {4'((k / 4) % 4), 4'((k / 16) * 4 + (k % 4))};
      e.cyc  = 1 + (k / 4) * 5 + (k % 4);
      sb_q.push_back(e);
    end
    for (int c = 0; c < 25; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (fire[i]) cnt[i] = cnt[i] + 4'd1;
        req_data[i*8 +: 8] = {4'(i), cnt[i]};
      end
      req_valid = 4'hF;
      @(negedge wr_clk);
      sb_check(c);
      fire = req_valid & req_ready;
      @(posedge wr_clk);
      #1;
    end
    req_valid = '0;
    for (int c = 25; c < 29; c++) begin
      @(negedge wr_clk);
      sb_check(c);
      @(posedge wr_clk);
      #1;
    end
    chk("rr_beats_left", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
